// File: rtl/btn_event_arb.sv
// btn_event_arb: classifies debounced button presses as short/long and arbitrates
//   the resulting events round-robin onto a single valid/ready event channel.
// Latency: ev_valid rises 2 edges after the release sample (short press) or
//   after the T_LONG-th high sample (long press), when the arbiter is idle.
// Backpressure: the offered event holds until ev_ready. Meanwhile each button
//   queues at most one short and one long event. A further event of a type
//   already queued is dropped and reported with a one-cycle ovf pulse.
//
// Ports:
//   clk      - system clock, rising edge
//   n_rst    - synchronous active-low reset
//   btn      - debounced button levels, 1 = pressed
//   ev_valid - event offered (registered state decode)
//   ev_ready - consumer accepts the offered event
//   ev_id    - index of the button that produced the offered event
//   ev_long  - 1 = long press, 0 = short press
//   ovf      - one-cycle pulse when at least one event was dropped
module btn_event_arb #(
  parameter int              ID_W    = 2,
  parameter int              NUM_BTN = 2**ID_W,
  parameter int              CW      = 26,
  parameter logic [CW-1:0]   T_LONG  = 26'd50_000_000
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [ID_W-1:0]    ev_id,
  output logic               ev_long,
  output logic               ovf
);

  localparam logic [CW-1:0] ONE   = {{(CW-1){1'b0}}, 1'b1};
  // Counter value one sample before a press becomes long.
  localparam logic [CW-1:0] T_PRE = T_LONG - ONE;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [NUM_BTN-1:0] prev_q;
  logic [CW-1:0]      cnt_q [NUM_BTN];
  logic [CW-1:0]      cnt_d [NUM_BTN];

  logic [NUM_BTN-1:0] sp_q;
  logic [NUM_BTN-1:0] lp_q;
  logic [NUM_BTN-1:0] sp_d;
  logic [NUM_BTN-1:0] lp_d;
  logic [NUM_BTN-1:0] sp_set;
  logic [NUM_BTN-1:0] lp_set;
  logic [NUM_BTN-1:0] sp_clr;
  logic [NUM_BTN-1:0] lp_clr;
  logic [NUM_BTN-1:0] sp_drop;
  logic [NUM_BTN-1:0] lp_drop;

  logic [ID_W-1:0]    last_q;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    win_id;
  logic               win_long;
  logic               found;
  logic               load;
  logic               hs;

  // ---------------------------------------------------------------------------
  // Hold counters and event detection
  // ---------------------------------------------------------------------------
  // cnt counts consecutive high samples of the current press and saturates at
  // T_LONG. Since it only passes through T_PRE once per press (saturation
  // stops it there), the long event fires exactly once even while held.
  always_comb begin
    sp_set = '0;
    lp_set = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (btn[i] && !prev_q[i]) begin
        cnt_d[i] = ONE;
      end else if (btn[i] && prev_q[i]) begin
        if (cnt_q[i] == T_LONG) begin
          cnt_d[i] = cnt_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
        lp_set[i] = (cnt_q[i] == T_PRE);
      end else if (!btn[i] && prev_q[i]) begin
        // A release after a press that already went long yields nothing.
        sp_set[i] = (cnt_q[i] < T_LONG);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin search, starting one past the last granted button
  // ---------------------------------------------------------------------------
  // NUM_BTN == 2**ID_W, so plain ID_W-bit addition wraps the search order.
  always_comb begin
    found    = 1'b0;
    win_id   = '0;
    win_long = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      cand = last_q + ID_W'(k);
      if (!found && (sp_q[cand] || lp_q[cand])) begin
        found    = 1'b1;
        win_id   = cand;
        // Long events outrank short ones within the same button.
        win_long = lp_q[cand];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (ev_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM: outputs and flag clears
  // ---------------------------------------------------------------------------
  always_comb begin
    ev_valid = (state_q == S_OFFER);
    load     = (state_q == S_IDLE) && found;
    hs       = (state_q == S_OFFER) && ev_ready;
    sp_clr   = '0;
    lp_clr   = '0;
    if (load) begin
      if (win_long) begin
        lp_clr[win_id] = 1'b1;
      end else begin
        sp_clr[win_id] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending flags
  // ---------------------------------------------------------------------------
  // A set coinciding with the clear of the same flag is a fresh event: the
  // flag stays up and nothing is dropped. A set onto a flag that survives the
  // cycle is a drop.
  always_comb begin
    sp_drop = sp_set & sp_q & ~sp_clr;
    lp_drop = lp_set & lp_q & ~lp_clr;
    sp_d    = sp_set | (sp_q & ~sp_clr);
    lp_d    = lp_set | (lp_q & ~lp_clr);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      prev_q  <= '0;
      sp_q    <= '0;
      lp_q    <= '0;
      last_q  <= ID_W'(NUM_BTN - 1);
      ev_id   <= '0;
      ev_long <= 1'b0;
      ovf     <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      prev_q <= btn;
      sp_q   <= sp_d;
      lp_q   <= lp_d;
      ovf    <= |{sp_drop, lp_drop};
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (load) begin
        ev_id   <= win_id;
        ev_long <= win_long;
      end
      if (hs) begin
        last_q <= ev_id;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_arb.sv
// tb_btn_event_arb: directed scenarios plus randomized traffic for btn_event_arb,
//   checked every cycle against a press-length / pending-event reference model.
// Model runs on each rising edge from the same inputs; outputs compared 1 ns later.
module tb_btn_event_arb;

  localparam int            ID_W    = 2;
  localparam int            NUM_BTN = 4;
  localparam int            CW      = 8;
  localparam logic [CW-1:0] T_LONG  = 8'd8;
  localparam int            TL      = 8;

  logic               clk;
  logic               n_rst;
  logic [NUM_BTN-1:0] btn;
  logic               ev_valid;
  logic               ev_ready;
  logic [ID_W-1:0]    ev_id;
  logic               ev_long;
  logic               ovf;

  btn_event_arb #(
    .ID_W    (ID_W),
    .NUM_BTN (NUM_BTN),
    .CW      (CW),
    .T_LONG  (T_LONG)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .btn      (btn),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_id    (ev_id),
    .ev_long  (ev_long),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Accepted events, encoded as id*2 + long.
  int got[$];
  int ovf_cnt = 0;

  // Reference model: press length as an unbounded count, pending events as
  // one bit per (button, type), and the offered event.
  int m_len [NUM_BTN];
  bit m_sp  [NUM_BTN];
  bit m_lp  [NUM_BTN];
  bit m_offer;
  bit m_long;
  bit m_ovf;
  int m_id;
  int m_last;

  task automatic chk(input string tag, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit set_s [NUM_BTN];
    bit set_l [NUM_BTN];
    bit hit;
    int w;
    if (!n_rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        m_len[i] = 0;
        m_sp[i]  = 0;
        m_lp[i]  = 0;
      end
      m_offer = 0;
      m_long  = 0;
      m_ovf   = 0;
      m_id    = 0;
      m_last  = NUM_BTN - 1;
      return;
    end
    // Classify from the number of consecutive high samples.
    for (int i = 0; i < NUM_BTN; i++) begin
      set_s[i] = 0;
      set_l[i] = 0;
      if (btn[i]) begin
        m_len[i]++;
        if (m_len[i] == TL) set_l[i] = 1;
      end else begin
        if (m_len[i] > 0 && m_len[i] < TL) set_s[i] = 1;
        m_len[i] = 0;
      end
    end
    // Arbitration on the flags as they stood before this edge.
    if (!m_offer) begin
      hit = 0;
      for (int k = 1; k <= NUM_BTN; k++) begin
        w = (m_last + k) % NUM_BTN;
        if (!hit && (m_sp[w] || m_lp[w])) begin
          hit     = 1;
          m_id    = w;
          m_long  = m_lp[w];
          m_offer = 1;
          if (m_lp[w]) m_lp[w] = 0;
          else         m_sp[w] = 0;
        end
      end
    end else if (ev_ready) begin
      m_last  = m_id;
      m_offer = 0;
    end
    // New events: a flag still up after the clear means the event is dropped.
    m_ovf = 0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (set_s[i]) begin
        if (m_sp[i]) m_ovf = 1;
        m_sp[i] = 1;
      end
      if (set_l[i]) begin
        if (m_lp[i]) m_ovf = 1;
        m_lp[i] = 1;
      end
    end
  endtask

  // One clock cycle: log a handshake, advance the model, compare all outputs.
  task automatic step();
    if (n_rst && ev_valid === 1'b1 && ev_ready) got.push_back(int'(ev_id) * 2 + int'(ev_long));
    @(posedge clk);
    model_edge();
    #1;
    chk("ev_valid", ev_valid, int'(m_offer));
    chk("ev_id",    ev_id,    m_id);
    chk("ev_long",  ev_long,  int'(m_long));
    chk("ovf",      ovf,      int'(m_ovf));
    if (ovf === 1'b1) ovf_cnt++;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  task automatic press(input int b, input int n);
    btn[b] = 1'b1;
    repeat (n) step();
    btn[b] = 1'b0;
  endtask

  // Steps until ev_valid is seen; lat counts the steps taken (bounded by max).
  task automatic wait_valid(input int max, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (ev_valid !== 1'b1 && lat < max);
  endtask

  task automatic do_reset();
    n_rst    = 1'b0;
    btn      = '0;
    ev_ready = 1'b0;
    step();
    n_rst    = 1'b1;
    got.delete();
    ovf_cnt  = 0;
  endtask

  initial begin
    int lat;
    int chg;
    logic [ID_W-1:0] hold_id;
    logic            hold_long;

    n_rst    = 1'b0;
    btn      = '0;
    ev_ready = 1'b0;

    // Reset state (model is in reset; step compares the reset values).
    do_reset();
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ovf", ovf, 0);

    // 1. Short press on button 2.
    ev_ready = 1'b1;
    press(2, 3);
    wait_valid(10, lat);
    chk("t1_latency", lat, 2);
    chk("t1_id", ev_id, 2);
    chk("t1_long", ev_long, 0);
    step();
    chk("t1_one_cycle", ev_valid, 0);
    drain(3);
    chk("t1_count", got.size(), 1);

    // 2. Long-press boundary on button 1.
    do_reset();
    ev_ready = 1'b1;
    press(1, TL - 1);
    drain(6);
    chk("t2_short_count", got.size(), 1);
    if (got.size() > 0) chk("t2_short_ev", got[0], 2);
    got.delete();
    btn[1] = 1'b1;
    repeat (TL - 1) step();
    wait_valid(10, lat);
    chk("t2_long_latency", lat, 2);
    drain(5);
    btn[1] = 1'b0;
    drain(6);
    chk("t2_long_count", got.size(), 1);
    if (got.size() > 0) chk("t2_long_ev", got[0], 3);
    got.delete();
    press(1, 100);
    drain(6);
    chk("t2_hold_count", got.size(), 1);
    if (got.size() > 0) chk("t2_hold_ev", got[0], 3);

    // 3. Round-robin fairness.
    do_reset();
    btn = 4'b1011;
    repeat (3) step();
    btn = 4'b0000;
    drain(3);
    ev_ready = 1'b1;
    drain(10);
    chk("t3_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("t3_first", got[0], 0);
      chk("t3_second", got[1], 2);
      chk("t3_third", got[2], 6);
    end
    got.delete();
    btn = 4'b1001;
    repeat (3) step();
    btn = 4'b0000;
    drain(10);
    chk("t3_re_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t3_re_first", got[0], 0);
      chk("t3_re_second", got[1], 6);
    end

    // 4. Backpressure.
    do_reset();
    btn = 4'b0101;
    repeat (3) step();
    btn = 4'b0000;
    wait_valid(10, lat);
    chk("t4_latency", lat, 2);
    hold_id   = ev_id;
    hold_long = ev_long;
    chg = 0;
    repeat (20) begin
      step();
      if (ev_valid !== 1'b1 || ev_id !== hold_id || ev_long !== hold_long) chg++;
    end
    chk("t4_stable", chg, 0);
    chk("t4_first_id", hold_id, 0);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    drain(5);
    chk("t4_one_hs", got.size(), 1);
    chk("t4_next_id", ev_id, 2);

    // 5. Overflow.
    do_reset();
    press(0, 3);
    drain(3);
    press(2, 2);
    drain(2);
    press(2, 2);
    drain(3);
    chk("t5_ovf_pulses", ovf_cnt, 1);
    ev_ready = 1'b1;
    drain(10);
    chk("t5_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t5_first", got[0], 0);
      chk("t5_second", got[1], 4);
    end

    // 6. Reset mid-offer with button 0 held.
    do_reset();
    press(1, 3);
    press(2, 3);
    drain(3);
    btn[0] = 1'b1;
    drain(2);
    chk("t6_offering", ev_valid, 1);
    n_rst = 1'b0;
    step();
    chk("t6_valid_rst", ev_valid, 0);
    n_rst = 1'b1;
    got.delete();
    repeat (TL - 1) step();
    wait_valid(10, lat);
    chk("t6_latency", lat, 2);
    chk("t6_id", ev_id, 0);
    chk("t6_long", ev_long, 1);
    ev_ready = 1'b1;
    step();
    btn[0] = 1'b0;
    drain(10);
    chk("t6_count", got.size(), 1);
    if (got.size() > 0) chk("t6_ev", got[0], 1);

    // Randomized traffic, light then heavy backpressure, rare resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if ($urandom_range(0, 6) == 0) btn[i] = ~btn[i];
      end
      ev_ready = ($urandom_range(0, 3) < ((c < 1500) ? 3 : 1));
      n_rst    = ($urandom_range(0, 399) != 0);
      step();
    end
    n_rst    = 1'b1;
    btn      = '0;
    ev_ready = 1'b1;
    drain(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_event_arb.md
# btn_event_arb

Collects debounced button levels from the per-button debounce blocks and classifies each press as short or long. It queues at most one pending event of each type per button and hands events one at a time to the doorlock control FSM over a valid/ready handshake. Round-robin arbitration shares the single event channel fairly among all buttons.

## Interface

Parameters:
- `ID_W`, default 2: button-index width.
- `NUM_BTN`, default `2**ID_W` (4): number of buttons. It must equal `2**ID_W`.
- `CW`, default 26: hold-counter width.
- `T_LONG`, default `26'd50_000_000` (1 s at 50 MHz): number of consecutive high cycles that classify a press as long. Legal range is 2 to `2**CW - 1`.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `n_rst`, input, 1: reset. One clock; reset is synchronous and active-low.
- `btn`, input, `NUM_BTN`: debounced button levels, 1 = pressed, synchronous to `clk`.
- `ev_valid`, output, 1: an event is offered.
- `ev_ready`, input, 1: the consumer accepts the offered event.
- `ev_id`, output, `ID_W`: index of the button that produced the event.
- `ev_long`, output, 1: event type, 1 = long press, 0 = short press.
- `ovf`, output, 1: one-cycle pulse when an event is dropped.

## Operation

Per-button state (i = 0 .. NUM_BTN-1):
- `prev[i]`: registered copy of `btn[i]`.
- `cnt[i]`: hold counter, `CW` bits.
- `sp[i]`: short-event pending flag.
- `lp[i]`: long-event pending flag.

Hold counter, evaluated every cycle:
- Rising edge (`btn=1`, `prev=0`): `cnt <= 1`.
- Held (`btn=1`, `prev=1`): `cnt <= cnt+1`, saturating at `T_LONG`. No wrap-around.
- On the edge where `cnt` transitions from `T_LONG-1` to `T_LONG`: set `lp[i]`. This happens once per press, even if the button stays held.
- Falling edge (`btn=0`, `prev=1`): if `cnt < T_LONG`, set `sp[i]`. In all cases `cnt <= 0`.
- A release after a long press produces no event.

Classification by press length, where L = number of consecutive high samples:
- L >= `T_LONG`: exactly one long event.
- L < `T_LONG`: exactly one short event.

Overflow:
- If a flag is set while it is already 1 and is not being cleared that cycle, the new event is dropped.
- `ovf` pulses high for exactly one cycle. When several flags overflow in the same cycle, there is still a single pulse.

Arbiter FSM (2 states):
- IDLE, `ev_valid=0`:
  - If any `sp` or `lp` flag is set, search buttons in round-robin order starting at `last+1` (mod `NUM_BTN`).
  - The first button with a pending flag wins.
  - Within the winning button, `lp` has priority over `sp`.
  - Register `ev_id` and `ev_long`, clear the chosen flag, and go to OFFER.
  - Otherwise stay in IDLE.
- OFFER, `ev_valid=1`:
  - `ev_id` and `ev_long` are held stable until the handshake completes.
  - On `ev_valid && ev_ready`: `last <= ev_id`, go to IDLE.
  - Otherwise stay in OFFER. `ev_valid` never drops without a handshake.

Flag updates:
- Set and clear of the same flag in the same cycle: set wins, and the result counts as a new event.
- Flags keep accumulating while in OFFER. At most 2·`NUM_BTN` events can be outstanding.

## Timing

- All outputs and state are registered. No combinational path from `btn` or `ev_ready` to any output.
- Reset values:
  - `ev_valid=0`, `ev_id=0`, `ev_long=0`, `ovf=0`.
  - All `prev`, `cnt`, `sp`, `lp` = 0.
  - State = IDLE.
  - `last = NUM_BTN-1`, so button 0 has first priority.
- Short-event latency:
  - Edge E0: `btn` is first sampled low after a press, and `sp` is set.
  - Edge E1: the arbiter loads the event.
  - `ev_valid` is high after E1, i.e. 2 cycles after the release sample, provided the arbiter was in IDLE with no other pending events.
- Long-event latency: `ev_valid` rises 2 edges after the `T_LONG`-th high sample.
- Throughput: at most one event every 2 cycles, because one IDLE cycle is inserted after each handshake.
- Reset mid-operation: all pending and in-flight events are discarded. A button still held when reset is released is treated as a fresh press starting from the first post-reset cycle.

## Test plan

1. Short press (`T_LONG=8`): `btn[2]` high for 3 cycles, then low.
   - `ev_valid` rises 2 cycles after the release sample, with `ev_id=2`, `ev_long=0`.
   - With `ev_ready=1` held, `ev_valid` lasts 1 cycle.
2. Long-press boundary (`T_LONG=8`):
   - `btn[1]` high for exactly 7 cycles: one short event.
   - `btn[1]` high for exactly 8 cycles: one long event 2 cycles after the 8th high sample, and no event on release.
   - `btn[1]` held for 100 cycles: still exactly one event.
3. Round-robin fairness:
   - Stimulus: `ev_ready=0`; short presses on buttons 0, 1 and 3 released in the same cycle; then `ev_ready=1`.
   - Required order: 0, 1, 3.
   - Then re-press 0 and 3 together: order 3... is not required; order is 0 then 3, because `last` was 3 and the search starts at 0.
4. Backpressure:
   - With `ev_ready=0` for 20 cycles, `ev_valid`, `ev_id` and `ev_long` stay constant.
   - Asserting `ev_ready` for one cycle completes exactly one handshake.
5. Overflow:
   - Stimulus: `ev_ready=0`, event in OFFER; button 2 produces two short presses.
   - The first press is queued. The second press gives a 1-cycle `ovf` pulse.
   - After draining, exactly one short event for id 2 appears.
6. Reset mid-offer:
   - Stimulus: assert `n_rst=0` for 1 cycle while in OFFER with pending flags, while `btn[0]` is held.
   - `ev_valid=0` on the next cycle and pending events are lost.
   - `btn[0]` held for `T_LONG` cycles after reset produces a long event for id 0.
